// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes (also used by the transmitter),
// the receiver state encoding and a small 2-of-3 vote helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the value both flops take during reset so the
// downstream logic sees a known, inactive level on release.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // two back-to-back flops; only q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver for 8N1 / 8O1 / 8E1 frames, bit-exact with the team's
// transmitter timing (bit period = div_ratio+1 clocks).
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over the samples at centre-1, centre and centre+1, and all
// decisions and outputs move one clock later.
//
// Output handshake: valid is a one-cycle strobe with no ready; rx_data,
// parity_err and frame_err change only in that cycle and hold until the
// next strobe, so the consumer must take the byte within about a frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int parity    = PAR_NONE,
    parameter int div_ratio = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int P  = div_ratio + 1;
    localparam int H  = P / 2;
    localparam int CW = $clog2(div_ratio + 1) + 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    // Counter values at which a decision is taken. With the vote enabled the
    // decision lands one cycle after the centre, so the next state starts its
    // count at 1 to keep every later centre on the same line position.
    localparam logic [CW-1:0] START_AT  = CW'(H - 1 + SKEW);
    localparam logic [CW-1:0] CENTRE_AT = CW'(P - 1 + SKEW);
    localparam logic [CW-1:0] ENTRY_CNT = CW'(SKEW);

    generate
        if (div_ratio < 3) begin : g_bad_div_ratio
            $error("uart_rx: div_ratio must be at least 3");
        end
    endgenerate

    logic            rxs;
    logic            bit_val;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_acc;
    logic            par_bad;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_line),
        .q   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d1;
    logic rxs_d2;

    // keep the two previous synchronised samples for the 2-of-3 vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxs_d1 <= 1'b1;
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d1 <= rxs;
            rxs_d2 <= rxs_d1;
        end
    end

    assign bit_val = maj3(rxs_d2, rxs_d1, rxs);
`else
    assign bit_val = rxs;
`endif

    // frame FSM: bit timing, deserialisation, parity and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            cnt   <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == START_AT) begin
                        if (bit_val) begin
                            // line back high at mid-start: a glitch, not a frame
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            cnt     <= ENTRY_CNT;
                            bit_idx <= '0;
                            par_acc <= 1'b0;
                            par_bad <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == CENTRE_AT) begin
                        cnt     <= ENTRY_CNT;
                        shreg   <= {bit_val, shreg[7:1]};
                        par_acc <= par_acc ^ bit_val;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= (parity != PAR_NONE) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (cnt == CENTRE_AT) begin
                        cnt     <= ENTRY_CNT;
                        state   <= STOP;
                        // par_acc ^ bit is 1 when data ones + parity bit is odd
                        par_bad <= (parity == PAR_ODD) ? ~(par_acc ^ bit_val)
                                                       : (par_acc ^ bit_val);
                    end
                end
                STOP: begin
                    if (cnt == CENTRE_AT) begin
                        cnt        <= ENTRY_CNT;
                        valid      <= 1'b1;
                        rx_data    <= shreg;
                        parity_err <= (parity == PAR_NONE) ? 1'b0 : par_bad;
                        frame_err  <= ~bit_val;
                        if (bit_val) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // held-low line: wait for release without issuing more frames
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: one instance without parity (channel 0) and one with
// even parity (channel 1), div_ratio=9 so a bit lasts 10 clocks.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV = 9;
    localparam int P   = DIV + 1;
    localparam int H   = P / 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] line = 2'b11;
    logic [7:0] rx_data_a [2];
    logic [1:0] valid_a;
    logic [1:0] perr_a;
    logic [1:0] ferr_a;
    logic [1:0] busy_a;

    uart_rx #(.parity(PAR_NONE), .div_ratio(DIV)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (line[0]),
        .rx_data    (rx_data_a[0]),
        .valid      (valid_a[0]),
        .parity_err (perr_a[0]),
        .frame_err  (ferr_a[0]),
        .busy       (busy_a[0])
    );

    uart_rx #(.parity(PAR_EVEN), .div_ratio(DIV)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (line[1]),
        .rx_data    (rx_data_a[1]),
        .valid      (valid_a[1]),
        .parity_err (perr_a[1]),
        .frame_err  (ferr_a[1]),
        .busy       (busy_a[1])
    );

    // ---------------- scoreboard state ----------------
    int n_vectors     = 0;
    int n_miscompares = 0;

    // expected frame = {frame_err, parity_err, data}, plus start-edge stamp
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    int         st_q0[$];
    int         st_q1[$];
    int         vt_q0[$];   // cycles at which channel 0 strobed valid

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input int ch);
        check($sformatf("ch%0d reset rx_data", ch), 32'(rx_data_a[ch]), 32'h0);
        check($sformatf("ch%0d reset valid", ch), 32'(valid_a[ch]), 32'h0);
        check($sformatf("ch%0d reset parity_err", ch), 32'(perr_a[ch]), 32'h0);
        check($sformatf("ch%0d reset frame_err", ch), 32'(ferr_a[ch]), 32'h0);
        check($sformatf("ch%0d reset busy", ch), 32'(busy_a[ch]), 32'h0);
    endtask

    // ---------------- reference model / monitor ----------------
    task automatic on_valid(input int ch);
        logic [9:0] e;
        int st;
        int lat;
        int nom;
        int empty;
        empty = (ch == 0) ? int'(exp_q0.size() == 0) : int'(exp_q1.size() == 0);
        if (empty != 0) begin
            check($sformatf("ch%0d unexpected valid", ch), 32'(valid_a[ch]), 32'h0);
        end else begin
            if (ch == 0) begin
                e  = exp_q0.pop_front();
                st = st_q0.pop_front();
                vt_q0.push_back(cyc);
            end else begin
                e  = exp_q1.pop_front();
                st = st_q1.pop_front();
            end
            check($sformatf("ch%0d rx_data", ch), 32'(rx_data_a[ch]), 32'(e[7:0]));
            check($sformatf("ch%0d parity_err", ch), 32'(perr_a[ch]), 32'(e[8]));
            check($sformatf("ch%0d frame_err", ch), 32'(ferr_a[ch]), 32'(e[9]));
            // nominal latency from the first clock seeing the fall: 2+H+9P(+P)-1, +/-1
            lat = cyc - (st + 1);
            nom = 1 + H + 9 * P + ((ch == 1) ? P : 0);
            check($sformatf("ch%0d latency %0d vs %0d", ch, lat, nom),
                  32'((lat >= nom - 1) && (lat <= nom + 1)), 32'h1);
        end
    endtask

    // sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (valid_a[ch] === 1'b1) on_valid(ch);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int ch, input logic v, input int n);
        line[ch] = v;
        repeat (n) @(negedge clk);
    endtask

    // Send one frame; ch1 adds the given parity bit. Expected flags follow
    // directly from the frame rules: even mode errs when ones(data)+pbit is odd,
    // frame error when the stop bit is low.
    task automatic send_frame(input int ch, input logic [7:0] data, input logic pbit,
                              input logic stop_bit, input int low_hold);
        logic [9:0] e;
        e[7:0] = data;
        e[8]   = (ch == 1) ? logic'((($countones(data) + int'(pbit)) % 2) == 1) : 1'b0;
        e[9]   = ~stop_bit;
        if (ch == 0) begin
            exp_q0.push_back(e);
            st_q0.push_back(cyc);
        end else begin
            exp_q1.push_back(e);
            st_q1.push_back(cyc);
        end
        drive(ch, 1'b0, P);
        for (int i = 0; i < 8; i++) drive(ch, data[i], P);
        if (ch == 1) drive(ch, pbit, P);
        drive(ch, stop_bit, P);
        if (!stop_bit) drive(ch, 1'b0, low_hold);
        line[ch] = 1'b1;
    endtask

    task automatic settle_and_check(input int ch, input string tag);
        drive(ch, 1'b1, 2 * P);
        check($sformatf("%s ch%0d frames outstanding", tag, ch),
              32'((ch == 0) ? exp_q0.size() : exp_q1.size()), 32'h0);
        check($sformatf("%s ch%0d busy idle", tag, ch), 32'(busy_a[ch]), 32'h0);
    endtask

    task automatic random_traffic(input int ch, input int n);
        logic [7:0] d;
        logic       pb;
        logic       sb;
        for (int k = 0; k < n; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 7) != 0);
            send_frame(ch, d, pb, sb, $urandom_range(0, 20));
            drive(ch, 1'b1, sb ? $urandom_range(0, 4) : $urandom_range(3, 6));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit saw_busy;

        // reset
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("ch0 idle busy after reset", 32'(busy_a[0]), 32'h0);

        // 1: plain 8N1 frame
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
        settle_and_check(0, "t1");

        // 2: even parity, good then bad then good
        send_frame(1, 8'h07, 1'b1, 1'b1, 0);
        drive(1, 1'b1, 3);
        send_frame(1, 8'h07, 1'b0, 1'b1, 0);
        drive(1, 1'b1, 2 * P);
        check("t2 parity_err held", 32'(perr_a[1]), 32'h1);
        send_frame(1, 8'h3A, 1'b0, 1'b1, 0);
        settle_and_check(1, "t2");
        check("t2 parity_err cleared", 32'(perr_a[1]), 32'h0);

        // 3: short glitch must be rejected
        saw_busy = 1'b0;
        line[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_busy |= busy_a[0];
        end
        line[0] = 1'b1;
        repeat (H + 3) begin
            @(negedge clk);
            saw_busy |= busy_a[0];
        end
        check("t3 glitch raised busy", 32'(saw_busy), 32'h1);
        check("t3 glitch busy released", 32'(busy_a[0]), 32'h0);

        // 4: stop bit low, line held low 40 cycles, then a clean frame
        send_frame(0, 8'h3C, 1'b0, 1'b0, 40 - P);
        drive(0, 1'b1, 4);
        check("t4 frame_err held", 32'(ferr_a[0]), 32'h1);
        send_frame(0, 8'h55, 1'b0, 1'b1, 0);
        settle_and_check(0, "t4");

        // 5: back-to-back frames without idle gap
        vt_q0.delete();
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
        settle_and_check(0, "t5");
        check("t5 pulse count", 32'(vt_q0.size()), 32'd2);
        if (vt_q0.size() == 2)
            check("t5 pulse spacing", 32'(vt_q0[1] - vt_q0[0]), 32'(10 * P));

        // 6: reset pulse in the middle of bit 7 of frame 0x81
        drive(0, 1'b0, P);
        for (int i = 0; i < 7; i++) drive(0, (i == 0) ? 1'b1 : 1'b0, P);
        check("t6 busy mid-frame", 32'(busy_a[0]), 32'h1);
        drive(0, 1'b1, 2);
        rst = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, P - 3 + P);
        settle_and_check(0, "t6 aborted");
        send_frame(0, 8'h81, 1'b0, 1'b1, 0);
        settle_and_check(0, "t6");

        // randomized traffic on both channels concurrently
        fork
            random_traffic(0, 20);
            random_traffic(1, 20);
        join
        settle_and_check(0, "rand");
        settle_and_check(1, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises an asynchronous 8N1 / 8O1 / 8E1 line into bytes. It pairs with the team's UART transmitter and sits downstream of the board RX pin. It presents each received byte with a one-cycle valid strobe and per-frame error flags to the consuming logic (command parser / FIFO). It uses the same bit timing as the transmitter, so a tx→rx loopback is bit-exact.

Parameters:
- parity, 0: parity mode (0 = none, 1 = odd, 2 = even). Must match the transmitter.
- div_ratio, 434: bit period is div_ratio+1 clk cycles. 434 gives ≈115.2 kbaud at 50 MHz.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_line  in  1  serial input; asynchronous; idles high
- rx_data  out  8  last received byte; LSB was received first
- valid  out  1  one-cycle pulse; rx_data and the flags are updated in the same cycle
- parity_err  out  1  parity mismatch on the frame flagged by valid; held until the next valid
- frame_err  out  1  stop bit sampled low on that frame; held until the next valid
- busy  out  1  high from start-edge detection until the block is back in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, rx_data = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Synchroniser flops preset to 1, so no false start is seen on release.
- rx_line passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Bit-timing counter cnt:
  - Width is clog2(div_ratio+1)+1; cleared on every state entry.
  - P = div_ratio+1 and H = (div_ratio+1)/2, with integer division.
- IDLE: when rxs=0, go to START, busy=1, cnt=0.
- START: at cnt==H-1, sample rxs.
  - If rxs=1, treat it as a glitch: return to IDLE, busy=0, no valid.
  - If rxs=0, go to DATA with bit index 0.
- DATA: every P cycles (cnt==P-1, i.e. the bit centre), shift rxs into a shift register LSB-first and toggle the parity accumulator when rxs=1.
  - After the 8th sample, go to PARITY if parity!=0, else go to STOP.
- PARITY: at cnt==P-1, sample the parity bit and compute the error.
  - Odd mode: error if (data ones + bit) is even.
  - Even mode: error if (data ones + bit) is odd.
  - Then go to STOP.
- STOP: at cnt==P-1, sample rxs. In the same cycle:
  - valid=1, rx_data=shift register, parity_err=(computed value, 0 if parity==0), frame_err=!rxs.
  - If rxs=1, go to IDLE and set busy=0.
  - If rxs=0, go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE and set busy=0. No further valid is issued during a held-low line.
- Latency: valid fires 2 + H + 8·P (+P with parity) + P − 1 cycles after the rx_line falling edge, ±1 for synchroniser phase.
- No back-pressure: the consumer must take rx_data within about one frame time, otherwise it is overwritten.
- A new start edge is accepted in the cycle after returning to IDLE, so back-to-back frames with a single stop bit are received.
- Parameter values div_ratio < 3 are illegal; flag them with an elaboration-time assertion.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit decision (start, data, parity and stop) is the 2-of-3 majority of rxs at cnt centre−1, centre and centre+1. The decision and all outputs move one cycle later.
- Not defined: a single sample at the centre, with the timing given above.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - rx state enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - The transmitter is to adopt the parity constants as well.
- One sub-module: sync_2ff, a generic 2-flop synchroniser with a reset value parameter. It is reusable for other async inputs.

Test Plan (div_ratio=9, P=10, for speed; serial stimulus generated by the team's transmitter where possible):
1. parity=0, send 0xA5 → single valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy low again after the stop bit.
2. parity=2, send 0x07 with parity bit 1 → rx_data=0x07, parity_err=0. Same frame with parity bit 0 → parity_err=1. Next good frame clears the flag.
3. rx_line pulled low for 3 cycles then high → no valid; busy returns to 0 within H+3 cycles.
4. Frame 0x3C with stop bit 0, line held low for 40 cycles → valid with frame_err=1, then no further valid until the line goes high. A following 0x55 frame is received cleanly.
5. Back-to-back 0x00 then 0xFF with no idle gap → two valid pulses exactly 10·P cycles apart, data correct.
6. Assert rst for 1 cycle mid-DATA of frame 0x81 → all outputs 0 immediately. The rest of the frame does not produce valid (no start found, or a glitch reject). The next full frame 0x81 is received correctly.
